// File: rtl/card_round_referee.sv
// Card game referee: collects one card per player, feeds compare,
// scores the rounds and declares the game winner.
module card_round_referee #(
   parameter int WIN_SCORE  = 3,
   parameter int MAX_ROUNDS = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       p1_valid,
   input  logic [3:0] p1_card,
   output logic       p1_ready,
   input  logic       p2_valid,
   input  logic [3:0] p2_card,
   output logic       p2_ready,
   output logic [3:0] cmp_p1_card,
   output logic [3:0] cmp_p2_card,
   input  logic [1:0] cmp_result,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [3:0] round_cnt,
   output logic       round_done,
   output logic [1:0] round_result,
   output logic       game_over,
   output logic [1:0] winner
);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      COMPARE,
      UPDATE,
      OVER
   } state_t;

   localparam logic [3:0] WIN_L = 4'(WIN_SCORE);
   localparam logic [3:0] RND_L = 4'(MAX_ROUNDS);

   state_t     state;
   logic       p1_got;
   logic       p2_got;
   logic       p1_take;
   logic       p2_take;
   logic       game_end;
   logic [1:0] final_winner;

   // Readys come only from registered state, never from valid
   assign p1_ready = (state == COLLECT) && !p1_got;
   assign p2_ready = (state == COLLECT) && !p2_got;
   assign p1_take  = p1_valid & p1_ready;
   assign p2_take  = p2_valid & p2_ready;

   assign game_end = (p1_score == WIN_L) || (p2_score == WIN_L) ||
                     (round_cnt == RND_L);

   always_comb begin
      final_winner = 2'b01;
      if (p1_score == WIN_L)
         final_winner = 2'b10;
      else if (p2_score == WIN_L)
         final_winner = 2'b11;
      else if (p1_score > p2_score)
         final_winner = 2'b10;
      else if (p2_score > p1_score)
         final_winner = 2'b11;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         p1_got       <= 1'b0;
         p2_got       <= 1'b0;
         cmp_p1_card  <= 4'd0;
         cmp_p2_card  <= 4'd0;
         p1_score     <= 4'd0;
         p2_score     <= 4'd0;
         round_cnt    <= 4'd0;
         round_done   <= 1'b0;
         round_result <= 2'b00;
         game_over    <= 1'b0;
         winner       <= 2'b00;
      end else begin
         round_done <= 1'b0;
         if (start && (state == IDLE || state == OVER)) begin
            state        <= COLLECT;
            p1_got       <= 1'b0;
            p2_got       <= 1'b0;
            p1_score     <= 4'd0;
            p2_score     <= 4'd0;
            round_cnt    <= 4'd0;
            round_result <= 2'b00;
            game_over    <= 1'b0;
            winner       <= 2'b00;
         end else begin
            unique case (state)
               IDLE: state <= IDLE;
               COLLECT: begin
                  if (p1_take) begin
                     cmp_p1_card <= p1_card;
                     p1_got      <= 1'b1;
                  end
                  if (p2_take) begin
                     cmp_p2_card <= p2_card;
                     p2_got      <= 1'b1;
                  end
                  if ((p1_got || p1_take) && (p2_got || p2_take))
                     state <= COMPARE;
               end
               COMPARE: begin
                  round_result <= cmp_result;
                  // 00 is a voided round: nothing is counted
                  unique case (cmp_result)
                     2'b10: begin
                        p1_score  <= p1_score + 4'd1;
                        round_cnt <= round_cnt + 4'd1;
                     end
                     2'b11: begin
                        p2_score  <= p2_score + 4'd1;
                        round_cnt <= round_cnt + 4'd1;
                     end
                     2'b01: round_cnt <= round_cnt + 4'd1;
                     default: round_cnt <= round_cnt;
                  endcase
                  p1_got     <= 1'b0;
                  p2_got     <= 1'b0;
                  round_done <= 1'b1;
                  state      <= UPDATE;
               end
               UPDATE: begin
                  if (game_end) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                     winner    <= final_winner;
                  end else begin
                     state <= COLLECT;
                  end
               end
               OVER: state <= OVER;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
